pipe_ctrl: RTL and testbench

- Central pipeline sequencer for the five-stage core with stall-capable instruction and data memories.
- Drives write-enable and flush for the four pipeline registers (if_id, id_ex, ex_mem, mem_wb) and the PC.
- Sequences multi-cycle memory accesses, load-use bubbles, control-transfer flushes and halt.
- Tracks stall statistics and a wait-timeout error.

---
 rtl/pipe_pkg.sv | 83 ++++++++
 rtl/pipe_ctrl_sat_counter.sv | 27 ++
 rtl/pipe_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pipe_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types, defaults and flow helpers for the pipeline sequencer
// Contents:
//   state_t   : sequencer state encoding (RUN, DWAIT, IWAIT, HALT)
//   ctrl_t    : bundle of all combinational control outputs
//   flow_ctrl : control for the redirect / load-use / fetch-miss / advance rules
//   flow_next : next state that goes with flow_ctrl
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        IWAIT = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam int CNT_W_DEF   = 16;
    localparam int TIMEOUT_DEF = 255;

    typedef struct packed {
        logic imem_en;
        logic dmem_en;
        logic pc_en;
        logic pc_redirect;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
    } ctrl_t;

    // Stage-register control once no data access is blocking the pipe.
    // A flushed register is always also enabled, because flush only takes
    // effect through the register's write path.
    function automatic ctrl_t flow_ctrl(input logic redirect,
                                        input logic load_use,
                                        input logic imem_done);
        ctrl_t c;
        c = '0;
        if (redirect) begin
            c.pc_en        = 1'b1;
            c.pc_redirect  = 1'b1;
            c.if_id_en     = 1'b1;
            c.id_ex_en     = 1'b1;
            c.ex_mem_en    = 1'b1;
            c.mem_wb_en    = 1'b1;
            c.if_id_flush  = 1'b1;
            c.id_ex_flush  = 1'b1;
            c.ex_mem_flush = 1'b1;
        end else if (load_use) begin
            // Hold PC and if_id, inject a bubble into id_ex.
            c.id_ex_en     = 1'b1;
            c.id_ex_flush  = 1'b1;
            c.ex_mem_en    = 1'b1;
            c.mem_wb_en    = 1'b1;
        end else if (!imem_done) begin
            // Fetch miss: PC holds, if_id gets a bubble, older work drains.
            c.if_id_en     = 1'b1;
            c.if_id_flush  = 1'b1;
            c.id_ex_en     = 1'b1;
            c.ex_mem_en    = 1'b1;
            c.mem_wb_en    = 1'b1;
        end else begin
            c.pc_en        = 1'b1;
            c.if_id_en     = 1'b1;
            c.id_ex_en     = 1'b1;
            c.ex_mem_en    = 1'b1;
            c.mem_wb_en    = 1'b1;
        end
        return c;
    endfunction

    function automatic state_t flow_next(input logic redirect,
                                         input logic load_use,
                                         input logic imem_done);
        if (!redirect && !load_use && !imem_done) begin
            return IWAIT;
        end
        return RUN;
    endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// rtl/pipe_ctrl_sat_counter.sv - saturating up-counter with synchronous clear
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (wins over inc)
//   inc      : increment by one, holding at all-ones
//   count    : current value
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - five-stage pipeline sequencer with memory-wait, hazard and halt handling
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   imem_Done, dmem_Done           : fetch data valid / data access complete
//   ex_mem_memReadorWrite          : ex_mem holds a load or store
//   load_use, redirect, mem_wb_halt: hazard, control transfer, halt reached mem_wb
//   imem_en, dmem_en               : memory requests
//   pc_en, pc_redirect             : PC write enable / redirect-target select
//   *_en, *_flush                  : stage register write enables / synchronous clears
//   halted, err                    : sticky halt and wait-timeout flags
//   stall_cycles                   : saturating count of PC-held cycles outside HALT
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_Done,
    input  logic             dmem_Done,
    input  logic             ex_mem_memReadorWrite,
    input  logic             load_use,
    input  logic             redirect,
    input  logic             mem_wb_halt,
    output logic             imem_en,
    output logic             dmem_en,
    output logic             pc_en,
    output logic             pc_redirect,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t              state, state_nxt;
    logic                imem_pend, pend_nxt;
    ctrl_t               ctrl;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                in_wait, next_wait, err_hit, dmem_miss;

    assign dmem_miss = ex_mem_memReadorWrite && !dmem_Done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            imem_pend <= 1'b0;
            halted    <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            imem_pend <= pend_nxt;
            halted    <= halted | (state_nxt == HALT);
            err       <= err | err_hit;
        end
    end

    always_comb begin
        ctrl      = '0;
        state_nxt = state;
        pend_nxt  = 1'b0;
        // Outputs are forced quiet while reset is held.
        if (!rst) begin
            case (state)
                RUN: begin
                    if (mem_wb_halt) begin
                        state_nxt = HALT;
                    end else if (dmem_miss) begin
                        ctrl.imem_en = 1'b1;
                        ctrl.dmem_en = 1'b1;
                        state_nxt    = DWAIT;
                        pend_nxt     = !imem_Done;
                    end else begin
                        ctrl         = flow_ctrl(redirect, load_use, imem_Done);
                        ctrl.imem_en = 1'b1;
                        ctrl.dmem_en = ex_mem_memReadorWrite;
                        state_nxt    = flow_next(redirect, load_use, imem_Done);
                    end
                end
                DWAIT: begin
                    // The access was issued on entry; no re-request while waiting.
                    if (!dmem_Done) begin
                        pend_nxt = imem_pend;
                    end else if (imem_pend) begin
                        ctrl.if_id_en    = 1'b1;
                        ctrl.if_id_flush = 1'b1;
                        ctrl.id_ex_en    = 1'b1;
                        ctrl.ex_mem_en   = 1'b1;
                        ctrl.mem_wb_en   = 1'b1;
                        state_nxt        = IWAIT;
                    end else begin
                        ctrl      = flow_ctrl(redirect, load_use, imem_Done);
                        state_nxt = flow_next(redirect, load_use, imem_Done);
                    end
                end
                IWAIT: begin
                    ctrl.dmem_en = ex_mem_memReadorWrite;
                    if (dmem_miss) begin
                        state_nxt = DWAIT;
                        pend_nxt  = !imem_Done;
                    end else if (redirect) begin
                        // The outstanding fetch belongs to the wrong path; drop it.
                        ctrl         = flow_ctrl(1'b1, load_use, imem_Done);
                        ctrl.dmem_en = ex_mem_memReadorWrite;
                        state_nxt    = RUN;
                    end else begin
                        ctrl.if_id_en  = 1'b1;
                        ctrl.id_ex_en  = 1'b1;
                        ctrl.ex_mem_en = 1'b1;
                        ctrl.mem_wb_en = 1'b1;
                        if (imem_Done) begin
                            ctrl.pc_en = 1'b1;
                            state_nxt  = RUN;
                        end else begin
                            ctrl.if_id_flush = 1'b1;
                        end
                    end
                end
                HALT: begin
                    state_nxt = HALT;
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

    assign imem_en      = ctrl.imem_en;
    assign dmem_en      = ctrl.dmem_en;
    assign pc_en        = ctrl.pc_en;
    assign pc_redirect  = ctrl.pc_redirect;
    assign if_id_en     = ctrl.if_id_en;
    assign id_ex_en     = ctrl.id_ex_en;
    assign ex_mem_en    = ctrl.ex_mem_en;
    assign mem_wb_en    = ctrl.mem_wb_en;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_flush  = ctrl.id_ex_flush;
    assign ex_mem_flush = ctrl.ex_mem_flush;

    // A DWAIT<->IWAIT hop is still one continuous wait, so the count carries over.
    assign in_wait   = (state == DWAIT) || (state == IWAIT);
    assign next_wait = (state_nxt == DWAIT) || (state_nxt == IWAIT);
    assign err_hit   = in_wait && next_wait && (wait_cnt == WAIT_LAST);

    sat_counter #(.W(WAIT_W)) u_wait_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (!next_wait),
        .inc   (in_wait),
        .count (wait_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   ((state != HALT) && !ctrl.pc_en),
        .count (stall_cycles)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

    logic        clk, rst;
    logic        imem_Done, dmem_Done, ex_mem_memReadorWrite;
    logic        load_use, redirect, mem_wb_halt;
    logic        imem_en, dmem_en, pc_en, pc_redirect;
    logic        if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush, ex_mem_flush;
    logic        halted, err;
    logic [15:0] stall_cycles;
    logic [10:0] vec;

    int n_vec = 0;
    int n_err = 0;

    // {imem_en, dmem_en, pc_en, pc_redirect, if_id/id_ex/ex_mem/mem_wb _en, if_id/id_ex/ex_mem _flush}
    localparam logic [10:0] V_IDLE   = 11'b00000000000;
    localparam logic [10:0] V_RUN    = 11'b10101111000;
    localparam logic [10:0] V_DMISS  = 11'b11000000000;
    localparam logic [10:0] V_RESUME = 11'b00101111000;
    localparam logic [10:0] V_IMISS  = 11'b10001111100;
    localparam logic [10:0] V_IWAIT  = 11'b00001111100;
    localparam logic [10:0] V_REDIR  = 11'b10111111111;
    localparam logic [10:0] V_IREDIR = 11'b00111111111;
    localparam logic [10:0] V_LU     = 11'b10000111010;

    assign vec = {imem_en, dmem_en, pc_en, pc_redirect, if_id_en, id_ex_en,
                  ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, ex_mem_flush};

    pipe_ctrl dut (
        .clk                   (clk),
        .rst                   (rst),
        .imem_Done             (imem_Done),
        .dmem_Done             (dmem_Done),
        .ex_mem_memReadorWrite (ex_mem_memReadorWrite),
        .load_use              (load_use),
        .redirect              (redirect),
        .mem_wb_halt           (mem_wb_halt),
        .imem_en               (imem_en),
        .dmem_en               (dmem_en),
        .pc_en                 (pc_en),
        .pc_redirect           (pc_redirect),
        .if_id_en              (if_id_en),
        .id_ex_en              (id_ex_en),
        .ex_mem_en             (ex_mem_en),
        .mem_wb_en             (mem_wb_en),
        .if_id_flush           (if_id_flush),
        .id_ex_flush           (id_ex_flush),
        .ex_mem_flush          (ex_mem_flush),
        .halted                (halted),
        .err                   (err),
        .stall_cycles          (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic i_done, input logic d_done, input logic mrw,
                         input logic lu, input logic redir, input logic halt);
        imem_Done             = i_done;
        dmem_Done             = d_done;
        ex_mem_memReadorWrite = mrw;
        load_use              = lu;
        redirect              = redir;
        mem_wb_halt           = halt;
        #1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(1, 1, 0, 0, 0, 0);
        chk("reset_ctrl", 32'(vec), 32'(V_IDLE));
        chk("reset_stall", 32'(stall_cycles), 0);
        chk("reset_halted", 32'(halted), 0);
        chk("reset_err", 32'(err), 0);
        cyc();
        rst = 1'b0;

        // Free-running flow
        repeat (5) begin
            drive(1, 1, 0, 0, 0, 0);
            chk("run_flow", 32'(vec), 32'(V_RUN));
            cyc();
        end
        chk("run_stall", 32'(stall_cycles), 0);

        // Data miss: 1 RUN miss cycle + 2 DWAIT cycles, then completion
        drive(1, 0, 1, 0, 0, 0);
        chk("dmiss_issue", 32'(vec), 32'(V_DMISS));
        cyc();
        repeat (2) begin
            drive(1, 0, 1, 0, 0, 0);
            chk("dwait_hold", 32'(vec), 32'(V_IDLE));
            cyc();
        end
        drive(1, 1, 1, 0, 0, 0);
        chk("dwait_done", 32'(vec), 32'(V_RESUME));
        cyc();
        chk("dmiss_stall", 32'(stall_cycles), 3);
        drive(1, 1, 0, 0, 0, 0);
        chk("dmiss_back_run", 32'(vec), 32'(V_RUN));
        cyc();

        // Fetch miss: RUN miss + 2 IWAIT cycles, then fetch returns
        drive(0, 1, 0, 0, 0, 0);
        chk("imiss_run", 32'(vec), 32'(V_IMISS));
        cyc();
        repeat (2) begin
            drive(0, 1, 0, 0, 0, 0);
            chk("iwait_hold", 32'(vec), 32'(V_IWAIT));
            cyc();
        end
        drive(1, 1, 0, 0, 0, 0);
        chk("iwait_done", 32'(vec), 32'(V_RESUME));
        cyc();
        chk("imiss_stall", 32'(stall_cycles), 6);

        // Simultaneous data and fetch miss
        drive(0, 0, 1, 0, 0, 0);
        chk("dual_issue", 32'(vec), 32'(V_DMISS));
        cyc();
        drive(0, 0, 1, 0, 0, 0);
        chk("dual_dwait", 32'(vec), 32'(V_IDLE));
        cyc();
        drive(0, 1, 1, 0, 0, 0);
        chk("dual_dwait_done", 32'(vec), 32'(V_IWAIT));
        cyc();
        drive(1, 0, 0, 0, 0, 0);
        chk("dual_iwait_done", 32'(vec), 32'(V_RESUME));
        cyc();
        chk("dual_stall", 32'(stall_cycles), 9);

        // Redirect beats load-use; then load-use alone
        drive(1, 1, 0, 1, 1, 0);
        chk("redir_over_lu", 32'(vec), 32'(V_REDIR));
        cyc();
        drive(1, 1, 0, 1, 0, 0);
        chk("load_use", 32'(vec), 32'(V_LU));
        cyc();
        chk("lu_stall", 32'(stall_cycles), 10);

        // Redirect while waiting on a fetch
        drive(0, 1, 0, 0, 0, 0);
        chk("imiss_run2", 32'(vec), 32'(V_IMISS));
        cyc();
        drive(0, 1, 0, 0, 1, 0);
        chk("iwait_redir", 32'(vec), 32'(V_IREDIR));
        cyc();
        drive(1, 1, 0, 0, 0, 0);
        chk("iredir_back_run", 32'(vec), 32'(V_RUN));
        cyc();
        chk("iredir_stall", 32'(stall_cycles), 11);

        // Long data wait: err on the 255th DWAIT cycle edge, waiting continues
        drive(1, 0, 1, 0, 0, 0);
        chk("long_issue", 32'(vec), 32'(V_DMISS));
        cyc();
        repeat (254) cyc();
        chk("timeout_before", 32'(err), 0);
        cyc();
        chk("timeout_at", 32'(err), 1);
        chk("timeout_still_wait", 32'(vec), 32'(V_IDLE));
        repeat (44) cyc();
        drive(1, 1, 1, 0, 0, 0);
        chk("long_done", 32'(vec), 32'(V_RESUME));
        cyc();
        chk("long_stall", 32'(stall_cycles), 311);
        drive(1, 1, 0, 0, 0, 0);
        chk("long_back_run", 32'(vec), 32'(V_RUN));
        chk("err_sticky", 32'(err), 1);
        cyc();

        // Halt is absorbing
        drive(1, 1, 0, 0, 0, 1);
        chk("halt_entry", 32'(vec), 32'(V_IDLE));
        cyc();
        chk("halted_set", 32'(halted), 1);
        chk("halt_stall", 32'(stall_cycles), 312);
        drive(0, 0, 1, 1, 1, 0);
        repeat (3) cyc();
        chk("halt_quiet", 32'(vec), 32'(V_IDLE));
        chk("halt_sticky", 32'(halted), 1);
        chk("halt_stall_frozen", 32'(stall_cycles), 312);

        // Reset from HALT
        rst = 1'b1;
        #1;
        chk("rst_halted", 32'(halted), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_stall", 32'(stall_cycles), 0);
        chk("rst_ctrl", 32'(vec), 32'(V_IDLE));
        cyc();
        rst = 1'b0;
        drive(1, 1, 0, 0, 0, 0);
        chk("post_rst_run", 32'(vec), 32'(V_RUN));
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
